// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM encoding and product-extension helpers for the MAC sequencer
package mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_REST = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  function automatic logic acc_w_ok(input int data_w, input int acc_w);
    return acc_w >= 2 * data_w;
  endfunction

  // Widens a prod_w-bit product to 64 bits; callers truncate to their accumulator width.
  function automatic logic [63:0] ext_product(input logic [63:0] product, input int prod_w,
                                              input logic sign);
    logic [63:0] r;
    logic        msb;
    msb = product[prod_w-1];
    for (int i = 0; i < 64; i++) begin
      r[i] = (i < prod_w) ? product[i] : (sign & msb);
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_acc_add.sv
// rtl/mul_acc_add.sv - extend a product to accumulator width and add it, flagging overflow
module mul_acc_add
  import mul_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [2*DATA_W-1:0] product,
  input  logic                sign,
  input  logic                clr,
  output logic [ACC_W-1:0]    sum,
  output logic                ovf_this
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   full;

  assign ext  = ACC_W'(ext_product(64'(product), 2 * DATA_W, sign));
  assign base = clr ? '0 : acc;
  assign full = {1'b0, base} + {1'b0, ext};
  assign sum  = full[ACC_W-1:0];

  // Signed: same-sign addends producing a different-sign sum; unsigned: carry out.
  always_comb begin
    ovf_this = 1'b0;
    if (!clr) begin
      if (sign) begin
        ovf_this = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
      end else begin
        ovf_this = full[ACC_W];
      end
    end
  end

endmodule

// File: rtl/mul_addshift.sv
// rtl/mul_addshift.sv - iterative shift-add multiplier with level en / done handshake
module mul_addshift #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sign,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_BUSY = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  logic [1:0]          st;
  logic [DATA_W-1:0]   ma;
  logic [DATA_W-1:0]   mb;
  logic                neg;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] accum;

  // Works on magnitudes; the most negative operand's magnitude still fits unsigned.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= M_IDLE;
      ma    <= '0;
      mb    <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      accum <= '0;
    end else begin
      case (st)
        M_IDLE: begin
          if (en) begin
            ma    <= (sign && op_a[DATA_W-1]) ? (~op_a + 1'b1) : op_a;
            mb    <= (sign && op_b[DATA_W-1]) ? (~op_b + 1'b1) : op_b;
            neg   <= sign & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            cnt   <= '0;
            accum <= '0;
            st    <= M_BUSY;
          end
        end
        M_BUSY: begin
          if (!en) begin
            st <= M_IDLE;
          end else begin
            if (mb[cnt]) accum <= accum + ({{DATA_W{1'b0}}, ma} << cnt);
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) st <= M_DONE;
          end
        end
        M_DONE: begin
          if (!en) st <= M_IDLE;
        end
        default: st <= M_IDLE;
      endcase
    end
  end

  assign done    = (st == M_DONE);
  assign product = neg ? (~accum + 1'b1) : accum;

endmodule

// File: rtl/mul_acc_seq.sv
// rtl/mul_acc_seq.sv - streaming MAC sequencer driving an iterative multiplier
module mul_acc_seq
  import mul_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic                in_sign,
  input  logic                in_clr,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_acc,
  output logic                out_ovf,
  output logic                mul_en,
  output logic                mul_sign,
  output logic [DATA_W-1:0]   mul_op_a,
  output logic [DATA_W-1:0]   mul_op_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_product
);

  if (!acc_w_ok(DATA_W, ACC_W)) begin : g_acc_w_check
    $error("mul_acc_seq: ACC_W must be at least 2*DATA_W");
  end

  logic [1:0]        state;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              sign_r;
  logic              clr_r;
  logic              last_r;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [ACC_W-1:0]  sum;
  logic              ovf_this;

  mul_acc_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc      (acc),
    .product  (mul_product),
    .sign     (sign_r),
    .clr      (clr_r),
    .sum      (sum),
    .ovf_this (ovf_this)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sign_r <= 1'b0;
      clr_r  <= 1'b0;
      last_r <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r    <= in_a;
            b_r    <= in_b;
            sign_r <= in_sign;
            clr_r  <= in_clr;
            last_r <= in_last;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            acc   <= sum;
            ovf   <= (clr_r ? 1'b0 : ovf) | ovf_this;
            state <= S_REST;
          end
        end
        // One cycle with en low so the multiplier re-arms before the next operand.
        S_REST: begin
          state <= last_r ? S_OUT : S_IDLE;
        end
        S_OUT: begin
          if (out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign mul_en    = (state == S_MUL);
  assign mul_sign  = sign_r;
  assign mul_op_a  = a_r;
  assign mul_op_b  = b_r;
  assign out_valid = (state == S_OUT);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul_acc_seq.sv
// tb/tb_mul_acc_seq.sv - directed self-checking bench for mul_acc_seq with mul_addshift attached
module tb_mul_acc_seq;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_W-1:0]   in_a = '0;
  logic [DATA_W-1:0]   in_b = '0;
  logic                in_sign = 1'b0;
  logic                in_clr = 1'b0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ACC_W-1:0]    out_acc;
  logic                out_ovf;
  logic                mul_en;
  logic                mul_sign;
  logic [DATA_W-1:0]   mul_op_a;
  logic [DATA_W-1:0]   mul_op_b;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mul_acc_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sign     (in_sign),
    .in_clr      (in_clr),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_ovf     (out_ovf),
    .mul_en      (mul_en),
    .mul_sign    (mul_sign),
    .mul_op_a    (mul_op_a),
    .mul_op_b    (mul_op_b),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  mul_addshift #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (mul_en),
    .sign    (mul_sign),
    .op_a    (mul_op_a),
    .op_b    (mul_op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Drives one beat and follows it through MUL and REST, checking en timing.
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic c, input logic l);
    int t = 0;
    wait_ready();
    in_valid = 1'b1; in_a = a; in_b = b; in_sign = s; in_clr = c; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul_en_after_accept", 32'(mul_en), 32'd1);
    check("in_ready_in_mul", 32'(in_ready), 32'd0);
    do begin
      @(negedge clk);
      t++;
    end while (!mul_done && t < 100);
    check("mul_done_seen", 32'(mul_done), 32'd1);
    @(posedge clk); #1;
    check("mul_en_low_rest", 32'(mul_en), 32'd0);
    check("out_valid_low_rest", 32'(out_valid), 32'd0);
    if (l) begin
      @(posedge clk); #1;
      check("out_valid_after_last", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic get_result(input logic [7:0] exp_acc, input logic exp_ovf);
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_acc", 32'(out_acc), 32'(exp_acc));
    check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("acc_cleared_after_hs", 32'(out_acc), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_acc", 32'(out_acc), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_mul_op_a", 32'(mul_op_a), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_mul_en", 32'(mul_en), 32'd0);

    // 1: -2 * -3 single beat
    beat(4'hE, 4'hD, 1'b1, 1'b1, 1'b1);
    get_result(8'h06, 1'b0);
    check("idle_mul_en_after1", 32'(mul_en), 32'd0);

    // 2: 6 - 6 - 4
    beat(4'h2, 4'h3, 1'b1, 1'b1, 1'b0);
    beat(4'hE, 4'h3, 1'b1, 1'b0, 1'b0);
    beat(4'hF, 4'h4, 1'b1, 1'b0, 1'b1);
    get_result(8'hFC, 1'b0);

    // 3: most-negative square, then signed wrap
    beat(4'h8, 4'h8, 1'b1, 1'b1, 1'b1);
    get_result(8'h40, 1'b0);
    beat(4'h7, 4'h7, 1'b1, 1'b1, 1'b0);
    beat(4'h7, 4'h7, 1'b1, 1'b0, 1'b0);
    beat(4'h7, 4'h7, 1'b1, 1'b0, 1'b1);
    get_result(8'h93, 1'b1);

    // 4: unsigned carry out
    beat(4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    beat(4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    get_result(8'hC2, 1'b1);

    // 5: backpressure, sequence without clr starts from zero
    beat(4'h3, 4'h5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_acc", 32'(out_acc), 32'h0F);
      check("bp_out_ovf", 32'(out_ovf), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_mul_en", 32'(mul_en), 32'd0);
    end
    get_result(8'h0F, 1'b0);

    // 6: reset while multiplying
    beat(4'h7, 4'h7, 1'b1, 1'b1, 1'b0);
    wait_ready();
    in_valid = 1'b1; in_a = 4'h5; in_b = 4'h6; in_sign = 1'b1; in_clr = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_mul_en_before", 32'(mul_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_mul_en", 32'(mul_en), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_acc", 32'(out_acc), 32'd0);
    check("abort_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    beat(4'h1, 4'h1, 1'b1, 1'b1, 1'b1);
    get_result(8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mul_acc_seq.md
Name: mul_acc_seq

Overview:
Sequencer that sits on both sides of the iterative shift-add multiplier (mul_addshift).
- Upstream: accepts operand pairs over a valid/ready stream and drives the multiplier's level-sensitive en/done protocol.
- Downstream: consumes each product on done and accumulates it, with overflow detection, into an ACC_W accumulator.
- Emits the accumulated result over a valid/ready output stream when the operation tagged last completes.
- Provides a streaming MAC front-end for the multiplier.

Parameters:
DATA_W, 4, operand width; must match the attached multiplier.
ACC_W, 16, accumulator width; must be >= 2*DATA_W.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept an operand beat.
in_a  in  DATA_W  operand A.
in_b  in  DATA_W  operand B.
in_sign  in  1  1 = signed (two's complement) multiply/accumulate, 0 = unsigned.
in_clr  in  1  first beat of a sequence: the accumulator is overwritten, not added to.
in_last  in  1  last beat of a sequence: the result is presented on out_*.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_acc  out  ACC_W  accumulated result.
out_ovf  out  1  sticky overflow for the sequence.
mul_en  out  1  multiplier enable (level).
mul_sign  out  1  multiplier sign mode.
mul_op_a  out  DATA_W  multiplier operand A.
mul_op_b  out  DATA_W  multiplier operand B.
mul_done  in  1  multiplier done.
mul_product  in  2*DATA_W  multiplier product.

Behaviour:
- Reset, synchronous and active-high: state IDLE; acc=0; ovf=0; out_valid=0; mul_en=0; mul_op_*, mul_sign and the operand registers are 0; in_ready=0 while rst=1.
- Reset mid-operation aborts: mul_en is 0 after the edge, any pending result is discarded, and acc/ovf are cleared.
- FSM states: IDLE, MUL, REST, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register a, b, sign, clr, last; go to MUL.
- MUL:
  - mul_en=1; mul_op_a, mul_op_b and mul_sign are driven from registers and stay stable for the whole state.
  - in_ready=0.
  - On the first cycle with mul_done=1:
    - Extend the product to ACC_W: sign-extend if sign=1, zero-extend if sign=0.
    - acc <= (clr ? 0 : acc) + ext.
    - ovf <= (clr ? 0 : ovf) | ovf_this.
    - Go to REST.
- Overflow rule (ovf_this):
  - sign=1: both addends have the same MSB and the sum MSB differs.
  - sign=0: carry out of bit ACC_W-1.
  - With clr=1 the addend is 0, so ovf_this=0.
- REST:
  - mul_en=0 for exactly one cycle, which guarantees the multiplier sees en low between operations.
  - Then go to OUT if last=1, else to IDLE.
- OUT:
  - out_valid=1, with out_acc=acc and out_ovf=ovf held stable; in_ready=0.
  - On out_ready: acc<=0, ovf<=0, out_valid<=0, go to IDLE.
- Latency:
  - Beat accepted at edge N; mul_en is high from N+1.
  - mul_done sampled at edge M; mul_en is low from M+1; out_valid is high from M+2 for a last beat.
  - Next beat acceptance is possible at M+2 at the earliest (non-last beats).
- mul_done while not in MUL is ignored. mul_product is sampled only at the done edge.
- in_clr=in_last=1 yields a single registered product.
- A sequence without a leading clr continues from the current acc, which is 0 after reset or after an output handshake.
- Wrap-around: acc wraps modulo 2^ACC_W; ovf flags the wrap.

Decomposition:
- Shared package (mul_pkg):
  - FSM state encoding as localparams.
  - ACC_W >= 2*DATA_W elaboration check.
  - Function ext_product(product, sign).
- One natural sub-module: mul_acc_add.
  - Combinational/registered extend-add with overflow.
  - Inputs: acc, product, sign, clr.
  - Outputs: sum, ovf_this.
  - The FSM remains in mul_acc_seq.
- Bench instantiates the real mul_addshift on the mul_* ports.

Test Plan:
1. DATA_W=4, ACC_W=8. Single signed beat a=-2, b=-3, clr=last=1 -> out_acc=0x06, ovf=0; mul_en high only during MUL.
2. Signed sequence (2,3,clr), (-2,3), (-1,4,last) -> out_acc=0xFC (-4), ovf=0; mul_en low >=1 cycle between beats.
3. Signed (-8,-8,clr,last) -> 0x40. Then signed (7,7,clr), (7,7), (7,7,last) -> out_acc=0x93, ovf=1.
4. Unsigned sign=0: (15,15,clr), (15,15,last) -> product 0xE1 zero-extended; out_acc=0xC2, ovf=1.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_acc/out_ovf stable, in_ready=0, mul_en=0. Release -> one handshake, then in_ready=1 next cycle, acc=0.
6. Assert rst for one cycle while in MUL -> mul_en=0, out_valid=0 after the edge. A following (1,1,clr,last) -> out_acc=0x01, ovf=0.
